// File: rtl/accum_pkg.sv
// Shared types and saturation bounds for the sequence accumulator.
// Bounds are built at a fixed wide width and truncated by the user to ACCW bits.
package accum_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  localparam int unsigned SAT_MAXW = 128;

  function automatic logic [SAT_MAXW-1:0] sat_max(input int unsigned w);
    return (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
  endfunction

  // Low w bits of the complement are 1000...0, the most negative w-bit value.
  function automatic logic [SAT_MAXW-1:0] sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational signed add of a DATAW beat into an ACCW partial sum,
// clamped to the ACCW signed range with an overflow indication.
module sat_adder
  import accum_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int ACCW  = 48
) (
  input  logic signed [ACCW-1:0]  partial,
  input  logic signed [DATAW-1:0] data,
  output logic signed [ACCW-1:0]  sum,
  output logic                    overflow
);

  localparam logic signed [ACCW-1:0] MAX_V = ACCW'(sat_max(ACCW));
  localparam logic signed [ACCW-1:0] MIN_V = ACCW'(sat_min(ACCW));

  logic signed [ACCW:0] wide;

  always_comb begin
    wide     = (ACCW+1)'(partial) + (ACCW+1)'(data);
    // One guard bit: overflow iff the top two bits of the wide sum disagree.
    overflow = wide[ACCW] ^ wide[ACCW-1];
    if (overflow) begin
      sum = wide[ACCW] ? MIN_V : MAX_V;
    end else begin
      sum = wide[ACCW-1:0];
    end
  end

endmodule

// File: rtl/seq_accumulator.sv
// Accumulates groups of signed beats into a saturating register and emits
// one result per group over a valid/ready handshake.
module seq_accumulator
  import accum_pkg::*;
#(
  parameter int DATAW        = 32,
  parameter int ACCW         = 48,
  parameter int LENW         = 8,
  parameter bit BACKPRESSURE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [DATAW-1:0] data_i,
  input  logic [LENW-1:0]         len_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic signed [ACCW-1:0]  acc_o,
  output logic                    sat_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  state_e                 state, state_n;
  logic [LENW-1:0]        cnt, cnt_n;
  logic [LENW-1:0]        len_q, len_n;
  logic [LENW-1:0]        first_len, cnt_inc;
  logic signed [ACCW-1:0] partial, partial_n;
  logic signed [ACCW-1:0] acc_n;
  logic signed [ACCW-1:0] add_sum;
  logic                   add_ovf;
  logic                   sat_q, sat_n, sat_out_n, valid_n;
  logic                   ds_ready, take, emit;

  assign ds_ready  = BACKPRESSURE ? ready_i : 1'b1;
  assign ready_o   = BACKPRESSURE ? (!valid_o || ready_i) : 1'b1;
  assign take      = valid_i && ready_o;
  assign first_len = (len_i == '0) ? LENW'(1) : len_i;
  assign cnt_inc   = cnt + LENW'(1);

  sat_adder #(
    .DATAW(DATAW),
    .ACCW (ACCW)
  ) u_add (
    .partial (partial),
    .data    (data_i),
    .sum     (add_sum),
    .overflow(add_ovf)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    len_n     = len_q;
    partial_n = partial;
    sat_n     = sat_q;
    acc_n     = acc_o;
    sat_out_n = sat_o;
    emit      = 1'b0;
    valid_n   = valid_o && !ds_ready;

    unique case (state)
      IDLE: begin
        if (take) begin
          len_n     = first_len;
          partial_n = ACCW'(data_i);
          sat_n     = 1'b0;
          cnt_n     = LENW'(1);
          // Single-beat groups complete without ever entering ACCUM.
          if (first_len == LENW'(1)) begin
            emit      = 1'b1;
            acc_n     = ACCW'(data_i);
            sat_out_n = 1'b0;
            cnt_n     = '0;
          end else begin
            state_n = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (take) begin
          partial_n = add_sum;
          sat_n     = sat_q | add_ovf;
          cnt_n     = cnt_inc;
          if (cnt_inc == len_q) begin
            emit      = 1'b1;
            acc_n     = add_sum;
            sat_out_n = sat_q | add_ovf;
            cnt_n     = '0;
            state_n   = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (emit) begin
      valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      partial <= '0;
      sat_q   <= 1'b0;
      acc_o   <= '0;
      sat_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      len_q   <= len_n;
      partial <= partial_n;
      sat_q   <= sat_n;
      acc_o   <= acc_n;
      sat_o   <= sat_out_n;
      valid_o <= valid_n;
    end
  end

endmodule

// File: tb/tb_seq_accumulator.sv
// Scoreboard bench for seq_accumulator: a wide instance (32/48) and a narrow
// saturating instance (8/8) share clock and reset.
module tb_seq_accumulator;

  typedef struct {
    longint acc;
    bit     sat;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic signed [31:0] a_data;
  logic [7:0]         a_len;
  logic               a_valid, a_ready_o, a_sat, a_valid_o, a_ready_i;
  logic signed [47:0] a_acc;

  logic signed [7:0]  b_data;
  logic [7:0]         b_len;
  logic               b_valid, b_ready_o, b_sat, b_valid_o, b_ready_i;
  logic signed [7:0]  b_acc;

  seq_accumulator #(.DATAW(32), .ACCW(48), .LENW(8), .BACKPRESSURE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_i(a_data), .len_i(a_len), .valid_i(a_valid),
    .ready_o(a_ready_o), .acc_o(a_acc), .sat_o(a_sat), .valid_o(a_valid_o), .ready_i(a_ready_i)
  );

  seq_accumulator #(.DATAW(8), .ACCW(8), .LENW(8), .BACKPRESSURE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_i(b_data), .len_i(b_len), .valid_i(b_valid),
    .ready_o(b_ready_o), .acc_o(b_acc), .sat_o(b_sat), .valid_o(b_valid_o), .ready_i(b_ready_i)
  );

  int     errors = 0;
  int     checks = 0;
  res_t   q_a[$];
  res_t   q_b[$];
  int     m_cnt[2];
  int     m_len[2];
  longint m_part[2];
  bit     m_sat[2];
  int     groups[2];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat_add(input longint a, input longint d, input int w,
                                     output bit ovf);
    longint hi, lo, s;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -hi - 1;
    s   = a + d;
    ovf = 1'b0;
    if (s > hi) begin
      s = hi; ovf = 1'b1;
    end else if (s < lo) begin
      s = lo; ovf = 1'b1;
    end
    return s;
  endfunction

  // One clock of stimulus on instance id, with scoreboard update and checks.
  task automatic cycle(input int id, input bit v, input longint d, input int len, input bit rdy);
    logic signed [63:0] acc_obs;
    logic vo, ro, so;
    bit   exp_ready, ovf;
    int   n_q;
    res_t r;
    @(negedge clk);
    if (id == 0) begin
      a_valid = v; a_data = 32'(d); a_len = 8'(len); a_ready_i = rdy;
      b_valid = 1'b0; b_ready_i = 1'b1;
    end else begin
      b_valid = v; b_data = 8'(d); b_len = 8'(len); b_ready_i = rdy;
      a_valid = 1'b0; a_ready_i = 1'b1;
    end
    #1;
    if (id == 0) begin
      vo = a_valid_o; ro = a_ready_o; so = a_sat; acc_obs = 64'(a_acc); n_q = q_a.size();
    end else begin
      vo = b_valid_o; ro = b_ready_o; so = b_sat; acc_obs = 64'(b_acc); n_q = q_b.size();
    end
    check("valid_o", vo, 64'(n_q > 0));
    exp_ready = (n_q == 0) || rdy;
    check("ready_o", ro, 64'(exp_ready));
    if (n_q > 0) begin
      if (id == 0) r = q_a[0]; else r = q_b[0];
      check("acc_o", acc_obs, r.acc);
      check("sat_o", so, 64'(r.sat));
      if (rdy) begin
        if (id == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
      end
    end
    if (v && exp_ready) begin
      if (m_cnt[id] == 0) begin
        m_len[id]  = (len == 0) ? 1 : len;
        m_part[id] = d;
        m_sat[id]  = 1'b0;
        m_cnt[id]  = 1;
      end else begin
        m_part[id] = sat_add(m_part[id], d, (id == 0) ? 48 : 8, ovf);
        m_sat[id]  = m_sat[id] | ovf;
        m_cnt[id]++;
      end
      if (m_cnt[id] == m_len[id]) begin
        r.acc = m_part[id];
        r.sat = m_sat[id];
        if (id == 0) q_a.push_back(r); else q_b.push_back(r);
        m_cnt[id] = 0;
        groups[id]++;
      end
    end
  endtask

  task automatic expect_now(input int id, input longint acc, input bit sat);
    @(posedge clk);
    #1;
    if (id == 0) begin
      check("direct valid_a", a_valid_o, 1);
      check("direct acc_a", 64'(a_acc), acc);
      check("direct sat_a", a_sat, 64'(sat));
    end else begin
      check("direct valid_b", b_valid_o, 1);
      check("direct acc_b", 64'(b_acc), acc);
      check("direct sat_b", b_sat, 64'(sat));
    end
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while (((id == 0) ? q_a.size() : q_b.size()) > 0 && n < 50) begin
      cycle(id, 1'b0, 0, 0, 1'b1);
      n++;
    end
    if (n >= 50) check("drain timeout", (id == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    check("rst valid_a", a_valid_o, 0);
    check("rst acc_a", 64'(a_acc), 0);
    check("rst sat_a", a_sat, 0);
    check("rst valid_b", b_valid_o, 0);
    #1 rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    m_cnt = '{0, 0};
  endtask

  task automatic random_run(input int id, input int n_groups);
    int target, budget, glen, len, prev;
    longint d;
    logic signed [31:0] d32;
    logic signed [7:0]  d8;
    target = groups[id] + n_groups;
    budget = 0;
    glen   = $urandom_range(1, 16);
    while (groups[id] < target && budget < 60000) begin
      len  = (m_cnt[id] == 0) ? glen : $urandom_range(0, 255);
      d32  = 32'($urandom());
      d8   = 8'($urandom_range(0, 255));
      d    = (id == 0) ? longint'(d32) : longint'(d8);
      prev = groups[id];
      cycle(id, $urandom_range(0, 3) != 0, d, len, $urandom_range(0, 3) != 0);
      if (groups[id] != prev) glen = $urandom_range(1, 16);
      budget++;
    end
    if (groups[id] < target) check("random timeout", groups[id], target);
    drain(id);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    a_valid = 1'b0; a_data = '0; a_len = '0; a_ready_i = 1'b1;
    b_valid = 1'b0; b_data = '0; b_len = '0; b_ready_i = 1'b1;
    m_cnt = '{0, 0};
    groups = '{0, 0};
    @(posedge clk);
    #1;
    check("reset valid_a", a_valid_o, 0);
    check("reset acc_a", 64'(a_acc), 0);
    check("reset sat_a", a_sat, 0);
    check("reset ready_a", a_ready_o, 1);
    check("reset valid_b", b_valid_o, 0);
    check("reset acc_b", 64'(b_acc), 0);
    @(negedge clk);
    rst_n = 1'b0;

    // Four-beat group
    cycle(0, 1, 1, 4, 1); cycle(0, 1, 2, 4, 1); cycle(0, 1, 3, 4, 1); cycle(0, 1, 4, 4, 1);
    expect_now(0, 10, 0);
    drain(0);

    // len_i == 0 behaves as single-beat groups, back to back
    cycle(0, 1, -5, 0, 1);
    expect_now(0, -5, 0);
    cycle(0, 1, 7, 0, 1);
    expect_now(0, 7, 0);
    drain(0);

    // Saturation on the narrow instance
    cycle(1, 1, 100, 3, 1); cycle(1, 1, 100, 3, 1); cycle(1, 1, -50, 3, 1);
    expect_now(1, 77, 1);
    drain(1);
    cycle(1, 1, -100, 2, 1); cycle(1, 1, -100, 2, 1);
    expect_now(1, -128, 1);
    drain(1);

    // Backpressure: result held, beats refused, then handoff plus new group
    cycle(0, 1, 9, 1, 1);
    repeat (5) cycle(0, 1, 100, 1, 0);
    cycle(0, 1, 11, 1, 1);
    expect_now(0, 11, 0);
    drain(0);

    // Reset mid-group discards the partial sum
    cycle(0, 1, 1, 4, 1); cycle(0, 1, 2, 4, 1);
    pulse_reset();
    cycle(0, 1, 3, 2, 1); cycle(0, 1, 4, 2, 1);
    expect_now(0, 7, 0);
    drain(0);

    // Random regression
    random_run(0, 1000);
    random_run(1, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
